// File: rtl/max7219_receiver_if.sv
// Serial bus of a MAX7219-style shift-register display driver: data, chip
// select, serial clock in, daisy-chain data out.
interface max7219_receiver_if;
  logic din;
  logic cs;
  logic sclk;
  logic dout;

  modport master (output din, output cs, output sclk, input dout);
  modport slave  (input din, input cs, input sclk, output dout);
endinterface

// File: rtl/max7219_receiver.sv
// MAX7219-compatible serial receiver: oversamples the SPI-like bus on clk,
// assembles 16-bit frames and latches them into the display register file.
module max7219_receiver (
  input  logic               clk,
  input  logic               rst_n,
  max7219_receiver_if.slave  sif,
  output logic               frame_valid,
  output logic               frame_err,
  output logic [3:0]         frame_addr,
  output logic [7:0]         frame_data,
  output logic [7:0]         decode_mode,
  output logic [3:0]         intensity,
  output logic [2:0]         scan_limit,
  output logic               shutdown_n,
  output logic               display_test,
  input  logic [2:0]         rd_digit,
  output logic [7:0]         rd_data
);
  typedef enum logic {IDLE, SHIFT} state_e;

  state_e          state_q, state_d;
  logic [1:0]      cs_sync_q, sclk_sync_q, din_sync_q;
  logic            cs_prev_q, sclk_prev_q;
  logic [15:0]     shift_reg_q, shift_reg_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0][7:0] digit_q, digit_d;
  logic [7:0]      decode_mode_q, decode_mode_d, frame_data_q, frame_data_d;
  logic [3:0]      intensity_q, intensity_d, frame_addr_q, frame_addr_d;
  logic [2:0]      scan_limit_q, scan_limit_d;
  logic            shutdown_n_q, shutdown_n_d, display_test_q, display_test_d;
  logic            frame_valid_q, frame_valid_d, frame_err_q, frame_err_d;
  logic            cs_s, sclk_s, din_s, cs_fall, cs_rise, sclk_rise;
  logic            shift_en, clr_cnt, eval_en;
  logic [3:0]      addr, dig_idx;

  // Synchronizers idle at the bus rest state so reset release creates no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q   <= 2'b11;
      sclk_sync_q <= 2'b00;
      din_sync_q  <= 2'b00;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], sif.cs};
      sclk_sync_q <= {sclk_sync_q[0], sif.sclk};
      din_sync_q  <= {din_sync_q[0], sif.din};
      cs_prev_q   <= cs_sync_q[1];
      sclk_prev_q <= sclk_sync_q[1];
    end
  end

  assign cs_s      = cs_sync_q[1];
  assign sclk_s    = sclk_sync_q[1];
  assign din_s     = din_sync_q[1];
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = SHIFT;
      SHIFT:   if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A cs edge in the same clk as an sclk rise wins; that sclk edge is dropped.
  always_comb begin
    shift_en = (state_q == SHIFT) && sclk_rise && !cs_rise && !cs_fall;
    clr_cnt  = (state_q == IDLE) && cs_fall;
    eval_en  = (state_q == SHIFT) && cs_rise;
  end

  assign addr    = shift_reg_q[11:8];
  assign dig_idx = addr - 4'd1;

  always_comb begin
    shift_reg_d    = shift_reg_q;
    bit_cnt_d      = bit_cnt_q;
    digit_d        = digit_q;
    decode_mode_d  = decode_mode_q;
    intensity_d    = intensity_q;
    scan_limit_d   = scan_limit_q;
    shutdown_n_d   = shutdown_n_q;
    display_test_d = display_test_q;
    frame_addr_d   = frame_addr_q;
    frame_data_d   = frame_data_q;
    frame_valid_d  = 1'b0;
    frame_err_d    = 1'b0;
    if (clr_cnt) bit_cnt_d = 5'd0;
    if (shift_en) begin
      shift_reg_d = {shift_reg_q[14:0], din_s};
      bit_cnt_d   = (bit_cnt_q == 5'd16) ? 5'd16 : bit_cnt_q + 5'd1;
    end
    if (eval_en) begin
      if (bit_cnt_q == 5'd16) begin
        frame_valid_d = 1'b1;
        frame_addr_d  = addr;
        frame_data_d  = shift_reg_q[7:0];
        case (addr)
          4'h1, 4'h2, 4'h3, 4'h4,
          4'h5, 4'h6, 4'h7, 4'h8: digit_d[dig_idx[2:0]] = shift_reg_q[7:0];
          4'h9:    decode_mode_d  = shift_reg_q[7:0];
          4'hA:    intensity_d    = shift_reg_q[3:0];
          4'hB:    scan_limit_d   = shift_reg_q[2:0];
          4'hC:    shutdown_n_d   = shift_reg_q[0];
          4'hF:    display_test_d = shift_reg_q[0];
          default: ;
        endcase
      end else begin
        frame_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg_q    <= '0;
      bit_cnt_q      <= '0;
      digit_q        <= '0;
      decode_mode_q  <= '0;
      intensity_q    <= '0;
      scan_limit_q   <= '0;
      shutdown_n_q   <= 1'b0;
      display_test_q <= 1'b0;
      frame_addr_q   <= '0;
      frame_data_q   <= '0;
      frame_valid_q  <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      shift_reg_q    <= shift_reg_d;
      bit_cnt_q      <= bit_cnt_d;
      digit_q        <= digit_d;
      decode_mode_q  <= decode_mode_d;
      intensity_q    <= intensity_d;
      scan_limit_q   <= scan_limit_d;
      shutdown_n_q   <= shutdown_n_d;
      display_test_q <= display_test_d;
      frame_addr_q   <= frame_addr_d;
      frame_data_q   <= frame_data_d;
      frame_valid_q  <= frame_valid_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign sif.dout     = shift_reg_q[15];
  assign frame_valid  = frame_valid_q;
  assign frame_err    = frame_err_q;
  assign frame_addr   = frame_addr_q;
  assign frame_data   = frame_data_q;
  assign decode_mode  = decode_mode_q;
  assign intensity    = intensity_q;
  assign scan_limit   = scan_limit_q;
  assign shutdown_n   = shutdown_n_q;
  assign display_test = display_test_q;
  assign rd_data      = digit_q[rd_digit];
endmodule

// File: tb/tb_max7219_receiver.sv
// Scoreboard bench for max7219_receiver: directed and random serial frames,
// expected frame results queued by a register-file model, popped by a monitor.
module tb_max7219_receiver;
  logic       clk, rst_n;
  logic       frame_valid, frame_err, shutdown_n, display_test;
  logic [3:0] frame_addr, intensity;
  logic [7:0] frame_data, decode_mode, rd_data;
  logic [2:0] scan_limit, rd_digit;

  max7219_receiver_if sif ();

  max7219_receiver dut (
    .clk(clk), .rst_n(rst_n), .sif(sif),
    .frame_valid(frame_valid), .frame_err(frame_err),
    .frame_addr(frame_addr), .frame_data(frame_data),
    .decode_mode(decode_mode), .intensity(intensity), .scan_limit(scan_limit),
    .shutdown_n(shutdown_n), .display_test(display_test),
    .rd_digit(rd_digit), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       err;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] dec;
    logic [3:0] inten;
    logic [2:0] scan;
    logic       shut;
    logic       test;
  } exp_t;

  exp_t       q[$];
  int         n_pass = 0, n_chk = 0;
  logic [7:0] m_dig[8];
  logic [7:0] m_dec;
  logic [3:0] m_inten;
  logic [2:0] m_scan;
  logic       m_shut, m_test;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    foreach (m_dig[i]) m_dig[i] = 8'h00;
    m_dec = 0; m_inten = 0; m_scan = 0; m_shut = 0; m_test = 0;
  endtask

  // Reference: a frame is whatever the last 16 shifted bits were; short frames do nothing.
  task automatic model_frame(input logic [31:0] w, input int n);
    exp_t e;
    logic [15:0] f;
    f = w[15:0];
    e = '0;
    if (n < 16) e.err = 1'b1;
    else begin
      e.addr = f[11:8];
      e.data = f[7:0];
      if (f[11:8] >= 4'h1 && f[11:8] <= 4'h8) m_dig[f[11:8] - 4'h1] = f[7:0];
      else if (f[11:8] == 4'h9) m_dec   = f[7:0];
      else if (f[11:8] == 4'hA) m_inten = f[3:0];
      else if (f[11:8] == 4'hB) m_scan  = f[2:0];
      else if (f[11:8] == 4'hC) m_shut  = f[0];
      else if (f[11:8] == 4'hF) m_test  = f[0];
    end
    e.dec = m_dec; e.inten = m_inten; e.scan = m_scan; e.shut = m_shut; e.test = m_test;
    q.push_back(e);
  endtask

  // Bits go out MSB first from w[n-1]; once 16 bits are in, dout must replay the stream head.
  task automatic send(input logic [31:0] w, input int n);
    sif.cs = 1'b0; #40;
    for (int j = 0; j < n; j++) begin
      sif.din = w[n-1-j]; #20;
      if (j >= 16) chk("dout", {63'd0, sif.dout}, {63'd0, w[n-1-(j-16)]});
      sif.sclk = 1'b1; #40;
      sif.sclk = 1'b0; #20;
    end
    #40;
    model_frame(w, n);
    sif.cs = 1'b1;
    #150;
  endtask

  task automatic check_digits(input string nm);
    for (int d = 0; d < 8; d++) begin
      rd_digit = 3'(d); #1;
      chk(nm, {56'd0, rd_data}, {56'd0, m_dig[d]});
      #9;
    end
  endtask

  task automatic check_zero(input string nm);
    chk(nm, {frame_valid, frame_err, frame_addr, frame_data, decode_mode, intensity,
             scan_limit, shutdown_n, display_test, sif.dout}, 64'd0);
  endtask

  logic prev_evt = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (prev_evt) chk("pulse_width", {62'd0, frame_valid, frame_err}, 64'd0);
      prev_evt = frame_valid | frame_err;
      if (frame_valid || frame_err) begin
        if (q.size() == 0) chk("unexpected_frame", {62'd0, frame_valid, frame_err}, 64'd0);
        else begin
          e = q.pop_front();
          chk("frame_kind", {62'd0, frame_valid, frame_err}, {62'd0, ~e.err, e.err});
          if (!e.err) chk("frame_addr_data", {frame_addr, frame_data}, {e.addr, e.data});
          chk("cfg_regs", {decode_mode, intensity, scan_limit, shutdown_n, display_test},
              {e.dec, e.inten, e.scan, e.shut, e.test});
        end
      end
    end else prev_evt = 1'b0;
  end

  initial begin
    logic [31:0] w;
    int          n;
    rst_n = 1'b0; sif.cs = 1'b1; sif.sclk = 1'b0; sif.din = 1'b0; rd_digit = 3'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset_outputs");
    check_digits("reset_digits");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send(32'h0C01, 16);
    chk("shutdown_n_set", {63'd0, shutdown_n}, 64'd1);
    send(32'h0105, 16);
    send(32'h0809, 16);
    check_digits("digits_0105_0809");
    send(32'h0A7, 12);
    chk("intensity_after_short", {60'd0, intensity}, 64'd0);
    send(32'h0A0F_0B07, 32);
    chk("burst_regs", {intensity, scan_limit}, {4'h0, 3'h7});

    // sclk activity with cs high must be ignored.
    repeat (4) begin
      sif.din = 1'($urandom); #20;
      sif.sclk = 1'b1; #40;
      sif.sclk = 1'b0; #20;
    end
    send(32'h0003, 16);
    check_digits("digits_after_noop");

    // Reset in the middle of 0x0FFF.
    sif.cs = 1'b0; #40;
    for (int j = 0; j < 8; j++) begin
      sif.din = w_bit(16'h0FFF, 15 - j); #20;
      sif.sclk = 1'b1; #40;
      sif.sclk = 1'b0; #20;
    end
    rst_n = 1'b0; #30;
    sif.cs = 1'b1; #20;
    model_reset();
    check_zero("midframe_reset");
    rst_n = 1'b1; #100;
    chk("display_test_after_abort", {63'd0, display_test}, 64'd0);
    send(32'h0F01, 16);
    chk("display_test_set", {63'd0, display_test}, 64'd1);

    for (int k = 0; k < 24; k++) begin
      w = $urandom;
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(4, 28)) : 16;
      send(w, n);
    end
    check_digits("digits_final");

    for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  function automatic logic w_bit(input logic [15:0] v, input int i);
    return v[i];
  endfunction
endmodule

// File: doc/max7219_receiver.md
MAX7219_RECEIVER -- requirements
Module: max7219_receiver

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single system clock; every register in the block is clocked by it.
REQ-002 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have port din, input, 1 bit: serial data, asynchronous to clk.
REQ-004 The block SHALL have port cs, input, 1 bit: chip select, active-low, asynchronous to clk.
REQ-005 The block SHALL have port sclk, input, 1 bit: serial clock, asynchronous to clk.
REQ-006 The block SHALL have port dout, output, 1 bit: daisy-chain output, equal to shift_reg[15].
REQ-007 The block SHALL have port frame_valid, output, 1 bit: one-clk pulse when an accepted frame is latched.
REQ-008 The block SHALL have port frame_err, output, 1 bit: one-clk pulse when a short frame is discarded.
REQ-009 The block SHALL have port frame_addr, output, 4 bits: address of the last accepted frame.
REQ-010 The block SHALL have port frame_data, output, 8 bits: data of the last accepted frame.
REQ-011 The block SHALL have port decode_mode, output, 8 bits: register 0x9.
REQ-012 The block SHALL have port intensity, output, 4 bits: register 0xA, bits [3:0].
REQ-013 The block SHALL have port scan_limit, output, 3 bits: register 0xB, bits [2:0].
REQ-014 The block SHALL have port shutdown_n, output, 1 bit: register 0xC, bit 0; 1 means normal operation.
REQ-015 The block SHALL have port display_test, output, 1 bit: register 0xF, bit 0.
REQ-016 The block SHALL have port rd_digit, input, 3 bits: digit register select for the read port.
REQ-017 The block SHALL have port rd_data, output, 8 bits: combinational contents of digit register rd_digit.

Function
REQ-018 The block SHALL pass each of din, cs and sclk through its own 2-FF synchronizer before any use.
REQ-019 The block SHALL detect sclk rising edges and cs rising and falling edges on the synchronized signals only.
REQ-020 The block SHALL sample synchronized din with the same delay as synchronized sclk, so bit alignment is preserved.
REQ-021 Correct operation SHALL require sclk high time and sclk low time each of at least 2 clk periods, and cs setup before the first sclk rise of at least 2 clk periods.
REQ-022 The block SHALL have states IDLE (cs high) and SHIFT (cs low).
REQ-023 A cs falling edge SHALL move IDLE to SHIFT and clear bit_cnt to 0.
REQ-024 A cs rising edge SHALL move SHIFT to IDLE and evaluate the frame.
REQ-025 In SHIFT, each sclk rising edge SHALL perform shift_reg <= {shift_reg[14:0], din}, MSB first.
REQ-026 In SHIFT, each sclk rising edge SHALL increment bit_cnt (5 bits), saturating at 16.
REQ-027 In IDLE, sclk edges SHALL be ignored and shift_reg and bit_cnt SHALL hold.
REQ-028 On cs rise with bit_cnt == 16, the frame SHALL be accepted: addr = shift_reg[11:8], data = shift_reg[7:0], bits [15:12] ignored.
REQ-029 For a frame longer than 16 bits, only the last 16 bits shifted SHALL be used.
REQ-030 On cs rise with bit_cnt < 16, no register SHALL change and frame_err SHALL pulse high for 1 clk.
REQ-031 An accepted frame SHALL update, on the clk after the synchronized cs rise is detected: digit[addr-1] for addr 0x1-0x8; decode_mode for 0x9; intensity for 0xA; scan_limit for 0xB; shutdown_n for 0xC; display_test for 0xF.
REQ-032 Addresses 0x0 (no-op) and 0xD-0xE SHALL leave all registers unchanged but still pulse frame_valid.
REQ-033 On every accepted frame, frame_addr and frame_data SHALL update and frame_valid SHALL pulse high for exactly 1 clk.
REQ-034 Latency from the cs rising edge at the pin to frame_valid high SHALL be 3 clk cycles (2 synchronizer stages + 1 register stage).
REQ-035 If a cs edge and an sclk rising edge are detected in the same clk, the cs edge SHALL take precedence and the sclk edge SHALL be ignored.
REQ-036 dout SHALL change only on sclk rising edges in SHIFT, so that a 32-bit burst passes the first 16 bits through to a downstream device.
REQ-037 rd_data SHALL be purely combinational from the digit registers and rd_digit.

Reset
REQ-038 While rst_n is low, all of the following SHALL be 0: digit[0..7], decode_mode, intensity, scan_limit, shutdown_n, display_test, frame_addr, frame_data, frame_valid, frame_err, shift_reg, bit_cnt, dout.
REQ-039 While rst_n is low, the state SHALL be IDLE and the synchronizers SHALL be loaded with cs=1, sclk=0, din=0.
REQ-040 Reset asserted mid-frame SHALL abort the frame with no register update; after release, the block SHALL wait for a new cs falling edge.

Verification
REQ-041 The bench SHALL cover: frame 0x0C01 -> shutdown_n=1, frame_valid pulses once, frame_addr=0xC, frame_data=0x01.
REQ-042 The bench SHALL cover: frames 0x0105 then 0x0809 -> rd_digit=0 gives rd_data=0x05; rd_digit=7 gives rd_data=0x09; other digits stay 0x00.
REQ-043 The bench SHALL cover: 12-bit frame 0x0A7 -> frame_err pulses 1 clk, intensity stays 0x0, no frame_valid.
REQ-044 The bench SHALL cover: 32-bit burst 0x0A0F_0B07 -> intensity=0x0, scan_limit=0x7; dout replays 0x0A0F during bits 17-32.
REQ-045 The bench SHALL cover: rst_n low after 8 bits of 0x0FFF -> display_test stays 0; a following full 0x0F01 frame sets display_test=1.
REQ-046 The bench SHALL cover: sclk pulses with cs high, then frame 0x0003 -> no register changes, frame_valid pulses, frame_addr=0x0.
